fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 172 +++++++++++++++++
 tb/tb_fetch_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- instruction fetch stage with a BOOT/RUN/HALT controller.
//
// Holds the program counter and the IF/ID pipeline register. Each RUN cycle
// fetches the word at imem_addr into IF/ID. A taken branch, resolved from the
// IF/ID contents, redirects the PC on the next edge. A branch-to-self
// (B #0) halts the stage until reset.
//
// Build option:
//   FETCH_DELAY_SLOT_EN  defined   : the word fetched in the cycle a taken
//                                    branch is sampled still enters IF/ID
//                                    (one architectural delay slot).
//                        undefined : that word is squashed to a NOP bubble.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   stall          in   hazard hold: PC and IF/ID keep their values
//   br_taken       in   branch held in IF/ID resolved taken
//   uncond_br      in   1 = imm26 offset (B), 0 = imm19 offset (CBZ/B.cond)
//   br_reg         in   1 = target comes from br_target_reg (BR)
//   br_target_reg  in   forwarded register value for BR
//   imem_rdata     in   combinational instruction-memory data for imem_addr
//   imem_addr      out  current PC
//   instruction    out  IF/ID instruction
//   pc_d           out  IF/ID copy of the PC the instruction came from
//   valid_d        out  IF/ID holds a real (non-bubble) instruction
//   halted         out  stage is in HALT
// ---------------------------------------------------------------------------
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        uncond_br,
  input  logic        br_reg,
  input  logic [63:0] br_target_reg,
  input  logic [31:0] imem_rdata,
  output logic [63:0] imem_addr,
  output logic [31:0] instruction,
  output logic [63:0] pc_d,
  output logic        valid_d,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [31:0] NOP = 32'h8B1F03FF;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        branch_go;
  logic        halt_req;
  logic [63:0] br_offset;
  logic [63:0] br_target;

  // Branch resolution looks only at IF/ID; a stalled cycle ignores br_taken
  // so the same branch is simply re-evaluated once the stall clears.
  assign branch_go = (state_q == ST_RUN) && !stall && br_taken;

  // Sign-extended word offset, already scaled by 4.
  assign br_offset = uncond_br
                   ? {{36{ifid_instr_q[25]}}, ifid_instr_q[25:0], 2'b00}
                   : {{43{ifid_instr_q[23]}}, ifid_instr_q[23:5], 2'b00};

  assign br_target = br_reg ? br_target_reg : (ifid_pc_q + br_offset);

  // B #0 jumps to itself forever; treat it as the program's halt.
  assign halt_req = branch_go && uncond_br && !br_reg
                 && (ifid_instr_q[25:0] == 26'd0);

  // ---------------- FSM: state register ----------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_BOOT;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: each combinational output gets a default before any branching, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt_req) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    halted = (state_q == ST_HALT);
  end

  // ---------------- PC and IF/ID next-state ----------------
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    unique case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (br_taken) begin
            fetch_pc_d = br_target;
            if (DELAY_SLOT) begin
              ifid_instr_d = imem_rdata;
              ifid_pc_d    = fetch_pc_q;
              ifid_valid_d = 1'b1;
            end else begin
              ifid_instr_d = NOP;
              ifid_valid_d = 1'b0;
            end
          end else begin
            fetch_pc_d   = fetch_pc_q + 64'd4;  // wraps silently at 2^64
            ifid_instr_d = imem_rdata;
            ifid_pc_d    = fetch_pc_q;
            ifid_valid_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
      end
      default: begin  // ST_BOOT
        fetch_pc_d   = 64'd0;
        ifid_instr_d = NOP;
        ifid_pc_d    = 64'd0;
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------- PC and IF/ID registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= 64'd0;
      ifid_instr_q <= NOP;
      ifid_pc_q    <= 64'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign instruction = ifid_instr_q;
  assign pc_d        = ifid_pc_q;
  assign valid_d     = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage -- self-checking bench for fetch_stage.
//
// A behavioural model tracks PC, IF/ID and run mode from the architectural
// rules; every clock it is compared with the DUT outputs. Directed scenarios
// cover boot, stall, B/CBZ/BR redirects, halt and PC wrap, followed by a
// randomized phase. Honours FETCH_DELAY_SLOT_EN like the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h8B1F03FF;
`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, uncond_br, br_reg;
  logic [63:0] br_target_reg;
  logic [31:0] imem_rdata;
  logic [63:0] imem_addr;
  logic [31:0] instruction;
  logic [63:0] pc_d;
  logic        valid_d;
  logic        halted;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .br_taken     (br_taken),
    .uncond_br    (uncond_br),
    .br_reg       (br_reg),
    .br_target_reg(br_target_reg),
    .imem_rdata   (imem_rdata),
    .imem_addr    (imem_addr),
    .instruction  (instruction),
    .pc_d         (pc_d),
    .valid_d      (valid_d),
    .halted       (halted)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_BOOT, M_RUN, M_HALT} mode_e;
  mode_e       m_mode = M_BOOT;
  logic [63:0] m_pc = '0, m_pcd = '0;
  logic [31:0] m_ins = NOP;
  bit          m_valid = 1'b0;
  bit          m_pcd_known = 1'b0;  // pc_d is only architecturally defined for real or reset contents

  // Instruction memory contents: distinct per word, never a B #0.
  function automatic logic [31:0] pattern(input logic [63:0] addr);
    return {8'hD5, addr[23:0]};
  endfunction

  task automatic model_step();
    longint      off;
    logic [63:0] tgt;
    bit          halt_now;
    if (reset) begin
      m_mode = M_BOOT; m_pc = '0; m_ins = NOP; m_pcd = '0;
      m_valid = 1'b0; m_pcd_known = 1'b1;
    end else begin
      case (m_mode)
        M_BOOT: begin
          m_mode = M_RUN; m_pc = '0; m_ins = NOP; m_pcd = '0;
          m_valid = 1'b0; m_pcd_known = 1'b1;
        end
        M_RUN: begin
          if (!stall) begin
            if (br_taken) begin
              if (uncond_br) off = longint'($signed(m_ins[25:0]));
              else           off = longint'($signed(m_ins[23:5]));
              tgt = br_reg ? br_target_reg : m_pcd + 64'(off * 4);
              halt_now = uncond_br && !br_reg && (m_ins[25:0] == 26'd0);
              if (DS) begin
                m_ins = imem_rdata; m_pcd = m_pc; m_valid = 1'b1; m_pcd_known = 1'b1;
              end else begin
                m_ins = NOP; m_valid = 1'b0; m_pcd_known = 1'b0;
              end
              m_pc = tgt;
              if (halt_now) m_mode = M_HALT;
            end else begin
              m_ins = imem_rdata; m_pcd = m_pc; m_valid = 1'b1; m_pcd_known = 1'b1;
              m_pc = m_pc + 64'd4;
            end
          end
        end
        default: begin  // M_HALT
          m_ins = NOP; m_valid = 1'b0; m_pcd_known = 1'b0;
        end
      endcase
    end
  endtask

  // One clock: advance the model with the applied inputs, then compare.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, ".addr"},  imem_addr,   m_pc);
    check({tag, ".instr"}, instruction, m_ins);
    check({tag, ".valid"}, valid_d,     m_valid);
    check({tag, ".halt"},  halted,      m_mode == M_HALT);
    if (m_pcd_known) check({tag, ".pcd"}, pc_d, m_pcd);
  endtask

  task automatic drive_idle();
    reset = 1'b0; stall = 1'b0; br_taken = 1'b0; uncond_br = 1'b0;
    br_reg = 1'b0; br_target_reg = '0; imem_rdata = pattern(m_pc);
  endtask

  task automatic tick_idle(input string tag);
    drive_idle();
    tick(tag);
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    tick("rst");
    reset = 1'b0;
  endtask

  // Free-run until the PC reaches addr (bounded).
  task automatic run_to(input logic [63:0] addr);
    for (int i = 0; i < 300 && !(m_mode == M_RUN && m_pc == addr); i++)
      tick_idle("run");
    check("run_to.addr", imem_addr, addr);
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    @(negedge clk);

    // Reset and boot sequence: 0 (BOOT), 0, 4, 8.
    do_reset();
    check("boot.addr", imem_addr, 64'h0);
    check("boot.valid", valid_d, 1'b0);
    check("boot.instr", instruction, NOP);
    tick_idle("b1");
    check("b1.addr", imem_addr, 64'h0);
    tick_idle("b2");
    check("b2.addr", imem_addr, 64'h4);
    check("b2.pcd", pc_d, 64'h0);
    tick_idle("b3");
    check("b3.addr", imem_addr, 64'h8);
    check("b3.pcd", pc_d, 64'h4);

    // Stall for two cycles at pc=8.
    for (int i = 0; i < 2; i++) begin
      drive_idle(); stall = 1'b1; br_taken = 1'b1;
      tick("stall");
      check("stall.addr", imem_addr, 64'h8);
      check("stall.pcd", pc_d, 64'h4);
      check("stall.instr", instruction, pattern(64'h4));
    end
    tick_idle("resume");
    check("resume.addr", imem_addr, 64'hC);

    // B #-2 at pc_d=0x20.
    do_reset();
    run_to(64'h20);
    drive_idle(); imem_rdata = 32'h17FFFFFE;
    tick("b_fetch");
    drive_idle(); br_taken = 1'b1; uncond_br = 1'b1;
    tick("b_take");
    check("bneg.addr", imem_addr, 64'h18);
    check("bneg.valid", valid_d, DS);
    check("bneg.instr", instruction, DS ? pattern(64'h24) : NOP);
    tick_idle("b_after");
    check("bneg.next", imem_addr, 64'h1C);

    // CBZ imm19=5 at pc_d=0x100, first sampled under stall.
    do_reset();
    run_to(64'h100);
    drive_idle(); imem_rdata = 32'hB40000A0;
    tick("cbz_fetch");
    drive_idle(); br_taken = 1'b1; stall = 1'b1;
    tick("cbz_stall");
    check("cbz.held", imem_addr, 64'h104);
    drive_idle(); br_taken = 1'b1;
    tick("cbz_take");
    check("cbz.addr", imem_addr, 64'h114);

    // B #0 halts; only reset leaves HALT.
    do_reset();
    run_to(64'h10);
    drive_idle(); imem_rdata = 32'h14000000;
    tick("h_fetch");
    drive_idle(); br_taken = 1'b1; uncond_br = 1'b1;
    tick("h_take");
    check("halt.flag", halted, 1'b1);
    check("halt.addr", imem_addr, 64'h10);
    for (int i = 0; i < 3; i++) begin
      drive_idle(); stall = i[0]; br_taken = 1'b1; uncond_br = 1'b1;
      tick("h_hold");
      check("halt.frozen", imem_addr, 64'h10);
      check("halt.bubble", valid_d, 1'b0);
    end
    do_reset();
    check("halt.reset_flag", halted, 1'b0);
    check("halt.reset_pc", imem_addr, 64'h0);

    // BR to the last word, then wrap.
    do_reset();
    tick_idle("w0");
    tick_idle("w1");
    drive_idle(); br_taken = 1'b1; br_reg = 1'b1;
    br_target_reg = 64'hFFFF_FFFF_FFFF_FFFC;
    tick("br_take");
    check("wrap.top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick_idle("wrap");
    check("wrap.zero", imem_addr, 64'h0);
    tick_idle("wrap2");
    check("wrap.pcd", pc_d, 64'h0);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      int r;
      reset         = ($urandom_range(0, 99) < 3);
      stall         = ($urandom_range(0, 99) < 25);
      br_taken      = m_valid && ($urandom_range(0, 99) < 30);
      uncond_br     = $urandom_range(0, 1) == 1;
      br_reg        = ($urandom_range(0, 99) < 25);
      br_target_reg = {$urandom, $urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      r = $urandom_range(0, 99);
      if (r < 6)       imem_rdata = 32'h14000000;
      else if (r < 18) imem_rdata = $urandom;
      else             imem_rdata = pattern(m_pc);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
